key_debouncer: RTL and testbench

Front-end conditioning stage for the board push-buttons ahead of the lab counter. The block performs three steps for each raw, bouncing, active-low key input:
- synchronises it to the system clock;
- debounces it with a per-key stability counter;
- emits clean active-high level, press-pulse and release-pulse signals.

The counter stage consumes `key_press_o` as its one-cycle "enter" strobe. An optional auto-repeat generator produces periodic press pulses while a key is held.

---
 rtl/key_debounce_pkg.sv | 14 +
 rtl/key_debounce_channel.sv | 150 +++++++++++++++
 rtl/key_debouncer.sv | 35 +++
 tb/tb_key_debouncer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-channel state
// encoding and the released (idle) raw key level.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HELD     = 2'd1,
        REPEAT   = 2'd2
    } key_state_e;

    // Raw keys are active-low, so an idle key reads as 1.
    localparam logic KEY_RELEASED_LVL = 1'b1;

endpackage

// File: rtl/key_debounce_channel.sv
// One push-button channel: two-flop synchroniser, per-key stability
// counter and registered level/press/release outputs.
// Optional auto-repeat FSM is built when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             press_evt;
    logic             release_evt;
    logic             press_nxt;
    logic             release_nxt;

    // Bring the asynchronous raw key into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= KEY_RELEASED_LVL;
            sync2 <= KEY_RELEASED_LVL;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // A level change is accepted on the last cycle of an unbroken run.
    assign accept      = (sync2 != stable) && (cnt == CNT_LAST);
    assign press_evt   = accept && (stable == KEY_RELEASED_LVL);
    assign release_evt = accept && (stable != KEY_RELEASED_LVL);

    // Count consecutive disagreeing samples; any agreement restarts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= KEY_RELEASED_LVL;
            cnt    <= '0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (accept) begin
            stable <= ~stable;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign level = ~stable;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RPT_W = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

    key_state_e       state;
    key_state_e       state_nxt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;

    // Repeat FSM state and timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RELEASED;
            rpt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rpt_cnt <= rpt_cnt_nxt;
        end
    end

    // Next state and pulse requests; a release wins over a coincident repeat tick.
    always_comb begin
        state_nxt   = state;
        rpt_cnt_nxt = rpt_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        unique case (state)
            RELEASED: begin
                if (press_evt) begin
                    state_nxt   = HELD;
                    rpt_cnt_nxt = '0;
                    press_nxt   = 1'b1;
                end
            end
            HELD: begin
                if (release_evt) begin
                    state_nxt   = RELEASED;
                    rpt_cnt_nxt = '0;
                    release_nxt = 1'b1;
                end else if (rpt_cnt == DELAY_LAST) begin
                    state_nxt   = REPEAT;
                    rpt_cnt_nxt = '0;
                    press_nxt   = 1'b1;
                end else begin
                    rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
                end
            end
            REPEAT: begin
                if (release_evt) begin
                    state_nxt   = RELEASED;
                    rpt_cnt_nxt = '0;
                    release_nxt = 1'b1;
                end else if (rpt_cnt == PERIOD_LAST) begin
                    rpt_cnt_nxt = '0;
                    press_nxt   = 1'b1;
                end else begin
                    rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
                end
            end
            default: begin
                state_nxt   = RELEASED;
                rpt_cnt_nxt = '0;
            end
        endcase
    end
`else
    // Without repeat, pulses follow the accepted edges of the stable level.
    assign press_nxt   = press_evt;
    assign release_nxt = release_evt;
`endif

    // Registered one-cycle pulses, aligned with the update of the stable level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Push-button front end: KEYS independent debounced channels producing
// active-high level, press and release outputs from active-low raw keys.
// Auto-repeat is included when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debouncer
    import key_debounce_pkg::*;
#(
    parameter int KEYS                 = 2,
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic            clk100_i,
    input  logic            rst_i,
    input  logic [KEYS-1:0] key_i,
    output logic [KEYS-1:0] key_level_o,
    output logic [KEYS-1:0] key_press_o,
    output logic [KEYS-1:0] key_release_o
);

    for (genvar i = 0; i < KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
        ) u_chan (
            .clk           (clk100_i),
            .rst           (rst_i),
            .key           (key_i[i]),
            .level         (key_level_o[i]),
            .press_pulse   (key_press_o[i]),
            .release_pulse (key_release_o[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random
// bouncing, checked against a sample-window reference model.
module tb_key_debouncer;

    localparam int KEYS = 2;
    localparam int DB   = 8;
    localparam int RD   = 20;
    localparam int RP   = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [KEYS-1:0] key;
    logic [KEYS-1:0] level;
    logic [KEYS-1:0] press;
    logic [KEYS-1:0] rel;

    int vectors     = 0;
    int miscompares = 0;
    int edge_no     = 0;

    // Reference model: raw samples per channel, newest at index 0.
    logic            hist [KEYS][DB+1];
    logic            m_stable [KEYS];
    int              m_press_edge [KEYS];
    logic [KEYS-1:0] e_level;
    logic [KEYS-1:0] e_press;
    logic [KEYS-1:0] e_rel;

    always #10 clk = ~clk;

    key_debouncer #(
        .KEYS                 (KEYS),
        .DEBOUNCE_CYCLES      (DB),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP)
    ) dut (
        .clk100_i      (clk),
        .rst_i         (rst),
        .key_i         (key),
        .key_level_o   (level),
        .key_press_o   (press),
        .key_release_o (rel)
    );

    task automatic model_reset();
        for (int c = 0; c < KEYS; c++) begin
            for (int j = 0; j <= DB; j++) hist[c][j] = 1'b1;
            m_stable[c]     = 1'b1;
            m_press_edge[c] = -1;
        end
        e_level = '0;
        e_press = '0;
        e_rel   = '0;
    endtask

    // A change is accepted once the DB most recent synchronised samples
    // (raw samples delayed two edges) all differ from the accepted level.
    task automatic model_edge(input logic [KEYS-1:0] k);
        for (int c = 0; c < KEYS; c++) begin
            bit all_diff = 1'b1;
            bit p = 1'b0;
            bit r = 1'b0;
            for (int j = 1; j <= DB; j++)
                if (hist[c][j] == m_stable[c]) all_diff = 1'b0;
            if (all_diff) begin
                if (m_stable[c]) begin
                    p = 1'b1;
                    m_press_edge[c] = edge_no;
                end else begin
                    r = 1'b1;
                end
                m_stable[c] = ~m_stable[c];
            end
`ifdef KEY_DEBOUNCE_REPEAT_EN
            else if (!m_stable[c] && m_press_edge[c] >= 0) begin
                int d = edge_no - m_press_edge[c];
                if (d >= RD && ((d - RD) % RP) == 0) p = 1'b1;
            end
`endif
            for (int j = DB; j >= 1; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = k[c];
            e_level[c] = ~m_stable[c];
            e_press[c] = p;
            e_rel[c]   = r;
        end
    endtask

    task automatic check_outputs();
        vectors++;
        assert (level === e_level) else begin
            miscompares++;
            $error("FAIL key_level_o edge %0d: got %b expected %b", edge_no, level, e_level);
        end
        vectors++;
        assert (press === e_press) else begin
            miscompares++;
            $error("FAIL key_press_o edge %0d: got %b expected %b", edge_no, press, e_press);
        end
        vectors++;
        assert (rel === e_rel) else begin
            miscompares++;
            $error("FAIL key_release_o edge %0d: got %b expected %b", edge_no, rel, e_rel);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; applies k across one rising edge.
    task automatic step(input logic [KEYS-1:0] k);
        key = k;
        @(posedge clk);
        edge_no++;
        model_edge(k);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asserts reset for n rising edges with key k, checking outputs stay clear.
    task automatic reset_cycles(input int n, input logic [KEYS-1:0] k);
        rst = 1'b1;
        key = k;
        model_reset();
        #1;
        check_outputs();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        int first;
        logic [KEYS-1:0] cur;
        int rem [KEYS];

        rst = 1'b1;
        key = 2'b11;
        model_reset();
        @(negedge clk);

        // Keys held through reset qualify as a normal press afterwards.
        reset_cycles(4, 2'b00);
        cnt_a = 0; first = -1;
        for (int i = 1; i <= 14; i++) begin
            step(2'b00);
            if (press === 2'b11) begin cnt_a++; if (first < 0) first = i; end
        end
        expect_int("reset_held_press_count", cnt_a, 1);
        expect_int("reset_held_press_edge", first, 10);
        cnt_a = 0;
        for (int i = 1; i <= 12; i++) begin
            step(2'b11);
            if (rel === 2'b11) cnt_a++;
        end
        expect_int("reset_held_release_count", cnt_a, 1);

        // Clean press and release on key 0.
        cnt_a = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            step(2'b10);
            if (press[0]) begin cnt_a++; if (first < 0) first = i; end
        end
`ifdef KEY_DEBOUNCE_REPEAT_EN
        expect_int("clean_press_count", cnt_a, 2);
`else
        expect_int("clean_press_count", cnt_a, 1);
`endif
        expect_int("clean_press_edge", first, 10);
        expect_int("clean_level", int'(level), 1);
        cnt_a = 0; first = -1;
        for (int i = 1; i <= 12; i++) begin
            step(2'b11);
            if (rel[0]) begin cnt_a++; if (first < 0) first = i; end
        end
        expect_int("clean_release_count", cnt_a, 1);
        expect_int("clean_release_edge", first, 10);
        expect_int("clean_level_after", int'(level), 0);

        // Bounce every 5 cycles is rejected; a final steady low is accepted.
        cnt_a = 0;
        for (int seg = 0; seg < 8; seg++)
            for (int i = 0; i < 5; i++) begin
                step({1'b1, seg[0]});
                if (press != 2'b00 || rel != 2'b00 || level != 2'b00) cnt_a++;
            end
        expect_int("bounce_activity", cnt_a, 0);
        cnt_a = 0; first = -1;
        for (int i = 1; i <= 12; i++) begin
            step(2'b10);
            if (press[0]) begin cnt_a++; if (first < 0) first = i; end
        end
        expect_int("bounce_press_count", cnt_a, 1);
        expect_int("bounce_press_edge", first, 10);
        for (int i = 0; i < 12; i++) step(2'b11);

        // A 7-cycle glitch on key 1 produces nothing.
        cnt_a = 0;
        for (int i = 0; i < 7; i++) begin
            step(2'b01);
            if (press != 2'b00 || rel != 2'b00 || level != 2'b00) cnt_a++;
        end
        for (int i = 0; i < 12; i++) begin
            step(2'b11);
            if (press != 2'b00 || rel != 2'b00 || level != 2'b00) cnt_a++;
        end
        expect_int("glitch_activity", cnt_a, 0);

        // Reset during a 6-cycle-old qualification restarts it from zero.
        for (int i = 0; i < 6; i++) step(2'b01);
        reset_cycles(2, 2'b01);
        cnt_a = 0; first = -1;
        for (int i = 1; i <= 12; i++) begin
            step(2'b01);
            if (press[1]) begin cnt_a++; if (first < 0) first = i; end
        end
        expect_int("reset_mid_qual_press_count", cnt_a, 1);
        expect_int("reset_mid_qual_press_edge", first, 10);
        for (int i = 0; i < 12; i++) step(2'b11);

        // Both keys together, then release of key 1 only.
        cnt_a = 0;
        for (int i = 0; i < 12; i++) begin
            step(2'b00);
            if (press === 2'b11) cnt_a++;
        end
        expect_int("both_press_same_cycle", cnt_a, 1);
        cnt_a = 0;
        for (int i = 0; i < 12; i++) begin
            step(2'b10);
            if (rel === 2'b10) cnt_a++;
        end
        expect_int("key1_release_only", cnt_a, 1);
        expect_int("key1_release_level", int'(level), 1);
        for (int i = 0; i < 12; i++) step(2'b11);

        // Long hold on key 0, then release landing on a repeat tick.
        cnt_a = 0;
        for (int i = 1; i <= 60; i++) begin
            step(2'b10);
            if (press[0]) cnt_a++;
        end
`ifdef KEY_DEBOUNCE_REPEAT_EN
        expect_int("repeat_press_count", cnt_a, 5);
`else
        expect_int("repeat_press_count", cnt_a, 1);
`endif
        cnt_a = 0; cnt_b = 0;
        for (int i = 1; i <= 12; i++) begin
            step(2'b11);
            if (press[0]) cnt_a++;
            if (rel[0]) cnt_b++;
        end
        expect_int("release_on_tick_press", cnt_a, 0);
        expect_int("release_on_tick_release", cnt_b, 1);

        // Random bouncing on both channels, with a reset in the middle.
        for (int c = 0; c < KEYS; c++) rem[c] = 0;
        cur = 2'b11;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < KEYS; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = 1'($urandom_range(0, 1));
                    rem[c] = $urandom_range(1, 40);
                end
                rem[c]--;
            end
            if (i == 300) reset_cycles(3, cur);
            step(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
